i2c_read_override: RTL and testbench
====================================

# i2c_read_override

Parametrised I2C read-data injector for the bus-attack test platform. It sits beside the I2CPhy decoder and tracks each frame. When a read is addressed to a programmable 7-bit target, it overwrites up to NUM_BYTES consecutive response bytes with a supplied pattern, using open-drain-style force-low/force-high strobes. It handles repeated START, stops on master NACK, and counts hit frames.

## Interface
- TARGET_ADDR, 7'h50, 7-bit slave address whose read frames are overridden
- NUM_BYTES, 4, number of response bytes overridden per frame (1..15)
- CNT_W, 8, width of hit counter
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- scl  in  1  synchronised I2C clock
- sda  in  1  synchronised I2C data
- i2c_start  in  1  one-clk pulse from I2CPhy on START / repeated START
- i2c_stop  in  1  one-clk pulse from I2CPhy on STOP
- i2c_data  in  1  one-clk pulse from I2CPhy when a bit is sampled (sda valid same cycle)
- en  in  1  global override enable
- pattern  in  8*NUM_BYTES  override bytes; byte n = pattern[8n+7:8n]
- mask  in  8*NUM_BYTES  per-bit override mask (only with I2C_OVR_MASK_EN)
- out_0  out  1  registered request to drive SDA low
- out_1  out  1  registered request to drive SDA high
- busy  out  1  high while in DATA state
- hit_count  out  CNT_W  saturating count of matched read frames

## Operation
- Slot counter bitcnt (4 bit) runs 8 down to 0 per byte: slots 8..1 = data bits 7..0 (MSB first), slot 0 = ACK. Byte counter bytecnt (4 bit).
- States: IDLE, ADDR, DATA, DONE.
- i2c_start in any state -> ADDR, bitcnt=8, bytecnt=0. Has priority over simultaneous i2c_data.
- i2c_stop -> IDLE from any state.
- ADDR: shift sampled bits into addr shift register. On ACK slot (bitcnt 0 sampled): if addr==TARGET_ADDR && rw==1 && en -> DATA, bytecnt=0, hit_count+=1 (saturating at all-ones); else -> DONE.
- DATA: each i2c_data decrements bitcnt; at slot 0 bitcnt reloads 8, bytecnt+1. Master ACK slot: sda==1 (NACK) -> DONE; bytecnt+1==NUM_BYTES -> DONE; else stay DATA.
- DONE: ignore data until START/STOP.
- Override condition ovr = (state==DATA) && en && bitcnt!=0. Bit value v = pattern[8*bytecnt + bitcnt-1]. write_0 = ovr && !v; write_1 = ovr && v.
- Slot 0 (master ACK) never driven.
- en deasserted: out_0/out_1 cleared next clk regardless of scl; frame tracking continues.

## Timing
- Reset: state IDLE, bitcnt 8, bytecnt 0, out_0=0, out_1=0, busy=0, hit_count=0. Reset mid-frame abandons frame; no override until next START.
- out_0/out_1 update on posedge clk only while scl==0 (1 clk latency from bitcnt change); hold value while scl high so SDA is stable across the sampling edge.
- Bit n override is presented in the scl-low phase preceding its sampling edge; released in the low phase before the ACK slot.
- busy rises the clk after address ACK slot; falls the clk after DONE/IDLE transition.
- out_0 and out_1 are never both 1.

## Configuration
- I2C_OVR_MASK_EN defined: mask port present; ovr additionally requires mask[8*bytecnt + bitcnt-1]==1. Unmasked bits are released (outputs 0), and the slave's original bits pass through.
- Undefined: no mask port; all 8 bits of each overridden byte are driven.

## Test plan
- Read to 0x50, 3 bytes, pattern byte0=8'h55, en=1 -> out_1/out_0 follow 0,1,0,1,0,1,0,1 over byte0 data slots, both 0 at ACK slots, hit_count=1.
- Read to 0x51 -> outputs stay 0 for whole frame, hit_count=0, state DONE.
- Write to 0x50 then repeated START read to 0x50 -> no override in write part; override begins on first read byte.
- Read of 6 bytes, NUM_BYTES=4 -> bytes 0..3 overridden, bytes 4..5 untouched; master NACK after byte 1 -> bytes 2+ untouched.
- rst asserted during byte 1 data slot 5 -> outputs 0 immediately, remaining bits untouched until next START.
- With I2C_OVR_MASK_EN, mask byte0=8'hF0, pattern 8'h00 -> out_0 high in slots 8..5 only.

Source files
------------

// File: rtl/i2c_read_override.sv
// rtl/i2c_read_override.sv - I2C read-data injector; optional per-bit mask via I2C_OVR_MASK_EN
module i2c_read_override #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_BYTES   = 4,
  parameter int         CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl,
  input  logic                   sda,
  input  logic                   i2c_start,
  input  logic                   i2c_stop,
  input  logic                   i2c_data,
  input  logic                   en,
  input  logic [8*NUM_BYTES-1:0] pattern,
`ifdef I2C_OVR_MASK_EN
  input  logic [8*NUM_BYTES-1:0] mask,
`endif
  output logic                   out_0,
  output logic                   out_1,
  output logic                   busy,
  output logic [CNT_W-1:0]       hit_count
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES);

  state_t     state;
  logic [3:0] bitcnt;
  logic [3:0] bytecnt;
  logic [7:0] addr_sh;

  logic [7:0] cur_pat;
  logic [7:0] cur_mask;
  logic [2:0] bit_idx;
  logic       ovr;
  logic       v;

  // Select the pattern (and mask) byte for the byte currently being read
  always_comb begin
    cur_pat  = '0;
    cur_mask = 8'hFF;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (bytecnt == 4'(i)) begin
        cur_pat = pattern[8*i +: 8];
`ifdef I2C_OVR_MASK_EN
        cur_mask = mask[8*i +: 8];
`endif
      end
    end
  end

  // Slot 8 maps to bit 7 ... slot 1 to bit 0; the 3-bit wrap makes slot 8 land on index 7
  always_comb begin
    bit_idx = bitcnt[2:0] - 3'd1;
    v       = cur_pat[bit_idx];
    ovr     = (state == DATA) && en && (bitcnt != 4'd0) && cur_mask[bit_idx];
  end

  // Frame tracker with registered drive strobes, busy flag and hit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= 4'd8;
      bytecnt   <= 4'd0;
      addr_sh   <= 8'd0;
      out_0     <= 1'b0;
      out_1     <= 1'b0;
      busy      <= 1'b0;
      hit_count <= '0;
    end else begin
      busy <= (state == DATA);

      // Strobes only move while SCL is low so SDA is stable across the sampling edge
      if (!en) begin
        out_0 <= 1'b0;
        out_1 <= 1'b0;
      end else if (!scl) begin
        out_0 <= ovr && !v;
        out_1 <= ovr && v;
      end

      if (i2c_start) begin
        state   <= ADDR;
        bitcnt  <= 4'd8;
        bytecnt <= 4'd0;
      end else if (i2c_stop) begin
        state   <= IDLE;
        bitcnt  <= 4'd8;
        bytecnt <= 4'd0;
      end else if (i2c_data) begin
        case (state)
          ADDR: begin
            if (bitcnt != 4'd0) begin
              addr_sh <= {addr_sh[6:0], sda};
              bitcnt  <= bitcnt - 4'd1;
            end else begin
              bitcnt  <= 4'd8;
              bytecnt <= 4'd0;
              if (addr_sh == {TARGET_ADDR, 1'b1} && en) begin
                state <= DATA;
                if (hit_count != '1)
                  hit_count <= hit_count + CNT_W'(1);
              end else begin
                state <= DONE;
              end
            end
          end
          DATA: begin
            if (bitcnt != 4'd0) begin
              bitcnt <= bitcnt - 4'd1;
            end else begin
              bitcnt  <= 4'd8;
              bytecnt <= bytecnt + 4'd1;
              if (sda || (bytecnt + 4'd1) == LAST_BYTE)
                state <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_read_override.sv
// tb/tb_i2c_read_override.sv - scoreboard bench for i2c_read_override against a frame-level model
module tb_i2c_read_override;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst, scl, sda, i2c_start, i2c_stop, i2c_data, en;
  logic [8*NB-1:0] pattern, mask;
  logic          out_0, out_1, busy;
  logic [7:0]    hit_count;

  logic [2:0]    exp_q[$];
  logic [2:0]    mon_e;
  int            vectors = 0;
  int            miscompares = 0;
  int            model_hit = 0;

  i2c_read_override #(.TARGET_ADDR(7'h50), .NUM_BYTES(NB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_data(i2c_data),
    .en(en), .pattern(pattern),
`ifdef I2C_OVR_MASK_EN
    .mask(mask),
`endif
    .out_0(out_0), .out_1(out_1), .busy(busy), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: each sampled bit is the point where the DUT presents its drive decision
  always @(negedge clk) begin
    if (i2c_data === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("slot_busy_out0_out1", {29'd0, busy, out_0, out_1}, {29'd0, mon_e});
        check("never_both", {31'd0, out_0 & out_1}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic low_phase(input logic b);
    scl = 1'b0;
    sda = b;
    step(4);
  endtask

  task automatic high_phase(input logic [2:0] e);
    exp_q.push_back(e);
    scl = 1'b1;
    i2c_data = 1'b1;
    step(1);
    i2c_data = 1'b0;
    step(3);
  endtask

  task automatic start_cond();
    scl = 1'b1; sda = 1'b1; step(2);
    sda = 1'b0; i2c_start = 1'b1; step(1);
    i2c_start = 1'b0; step(2);
  endtask

  task automatic stop_cond();
    scl = 1'b0; sda = 1'b0; step(2);
    scl = 1'b1; step(2);
    sda = 1'b1; i2c_stop = 1'b1; step(1);
    i2c_stop = 1'b0; step(2);
  endtask

  // One frame; ev_kind 1 = reset at (ev_byte, ev_slot), 2 = en dropped at that slot
  task automatic frame(input logic [6:0] a, input logic rw, input int nbytes,
                       input logic [15:0] nack, input bit do_stop,
                       input int ev_kind, input int ev_byte, input int ev_slot);
    logic [7:0] abyte, d;
    logic       b, pb, mb, act;
    bit         indata, en_ok;
    abyte = {a, rw};
    start_cond();
    for (int s = 8; s >= 1; s--) begin
      low_phase(abyte[s-1]);
      high_phase(3'b000);
    end
    low_phase(1'b0);
    high_phase(3'b000);
    indata = (a == 7'h50) && rw && en;
    en_ok  = 1'b1;
    if (indata && model_hit < 255) model_hit++;
    for (int k = 0; k < nbytes; k++) begin
      d = 8'($urandom);
      for (int s = 8; s >= 0; s--) begin
        b = (s == 0) ? nack[k] : d[s-1];
        low_phase(b);
        if (ev_kind == 1 && k == ev_byte && s == ev_slot) begin
          rst = 1'b1;
          #1;
          check("rst_outputs", {30'd0, out_0, out_1}, 32'd0);
          check("rst_hit_count", {24'd0, hit_count}, 32'd0);
          @(negedge clk);
          rst = 1'b0;
          step(1);
          indata = 1'b0;
          model_hit = 0;
        end
        if (ev_kind == 2 && k == ev_byte && s == ev_slot) begin
          scl = 1'b1;
          en = 1'b0;
          step(2);
          check("en_drop_outputs", {30'd0, out_0, out_1}, 32'd0);
          en_ok = 1'b0;
        end
        pb = (k < NB && s > 0) ? pattern[8*k + s - 1] : 1'b0;
`ifdef I2C_OVR_MASK_EN
        mb = (k < NB && s > 0) ? mask[8*k + s - 1] : 1'b0;
`else
        mb = 1'b1;
`endif
        act = indata && en_ok && (s != 0) && mb;
        high_phase({indata, act && !pb, act && pb});
      end
      if (nack[k] || k + 1 >= NB) indata = 1'b0;
    end
    if (do_stop) stop_cond();
    if (ev_kind == 2) en = 1'b1;
    check("hit_count", {24'd0, hit_count}, model_hit);
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    i2c_start = 1'b0; i2c_stop = 1'b0; i2c_data = 1'b0; en = 1'b1;
    pattern = '0; mask = '1;
    step(3);
    check("reset_out_0", {31'd0, out_0}, 32'd0);
    check("reset_out_1", {31'd0, out_1}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hit_count", {24'd0, hit_count}, 32'd0);
    rst = 1'b0;
    step(2);

    // Byte0 = 0x55 over a 3-byte read ending in master NACK
    pattern = 32'hC3A5_F055;
    frame(7'h50, 1'b1, 3, 16'h0004, 1'b1, 0, 0, 0);
    // Other address
    frame(7'h51, 1'b1, 3, 16'h0004, 1'b1, 0, 0, 0);
    // Write then repeated START read
    pattern = 32'h1234_9A6E;
    frame(7'h50, 1'b0, 2, 16'h0000, 1'b0, 0, 0, 0);
    frame(7'h50, 1'b1, 2, 16'h0002, 1'b1, 0, 0, 0);
    // Longer than NUM_BYTES
    frame(7'h50, 1'b1, 6, 16'h0020, 1'b1, 0, 0, 0);
    // Early master NACK after byte 1
    frame(7'h50, 1'b1, 4, 16'h0002, 1'b1, 0, 0, 0);
    // en dropped mid byte 0
    pattern = 32'h0F0F_00FF;
    frame(7'h50, 1'b1, 3, 16'h0004, 1'b1, 2, 0, 6);
    // Reset during byte 1 slot 5
    frame(7'h50, 1'b1, 3, 16'h0004, 1'b1, 1, 1, 5);
`ifdef I2C_OVR_MASK_EN
    pattern = 32'h0000_0000;
    mask    = 32'h0000_00F0;
    frame(7'h50, 1'b1, 1, 16'h0001, 1'b1, 0, 0, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [6:0]  ra;
      logic [15:0] rn;
      int          nb;
      ra = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'($urandom);
      nb = $urandom_range(1, 6);
      rn = ($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, nb - 1)) : 16'h0;
      en = ($urandom_range(0, 3) != 0);
      pattern = $urandom;
      mask    = $urandom;
      frame(ra, 1'($urandom), nb, rn, 1'($urandom), 0, 0, 0);
    end
    en = 1'b1;

    step(10);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
